// File: rtl/pulse_param_loader_pkg.sv
// pulse_param_loader_pkg: register map, reset defaults and state types shared by the parameter loader
package pulse_param_loader_pkg;

   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam logic [7:0] ADDR_PER    = 8'h01;
   localparam logic [7:0] ADDR_P1WID  = 8'h02;
   localparam logic [7:0] ADDR_DEL    = 8'h03;
   localparam logic [7:0] ADDR_P2WID  = 8'h04;
   localparam logic [7:0] ADDR_NUT_W  = 8'h05;
   localparam logic [7:0] ADDR_NUT_D  = 8'h06;
   localparam logic [7:0] ADDR_CP     = 8'h07;
   localparam logic [7:0] ADDR_P_BL   = 8'h08;
   localparam logic [7:0] ADDR_BL_OFF = 8'h09;
   localparam logic [7:0] ADDR_BL     = 8'h0A;
   localparam logic [7:0] ADDR_COMMIT = 8'h0F;

   // payload length marker for addresses outside the register map
   localparam logic [2:0] LEN_BAD = 3'd7;

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_CSUM} state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   typedef struct packed {
      logic [31:0] per;
      logic [15:0] p1wid;
      logic [15:0] del;
      logic [15:0] p2wid;
      logic [7:0]  nut_w;
      logic [15:0] nut_d;
      logic [7:0]  cp;
      logic [7:0]  p_bl;
      logic [15:0] p_bl_off;
      logic        bl;
   } params_t;

   // same power-up values the pulse sequencer assumes
   localparam params_t PARAM_DEFAULTS = '{
      per: 32'd65536, p1wid: 16'd30, del: 16'd200, p2wid: 16'd30, nut_w: 8'd50,
      nut_d: 16'd300, cp: 8'd3, p_bl: 8'd50, p_bl_off: 16'd100, bl: 1'b1
   };

   // number of DATA bytes that follow a given address byte
   function automatic logic [2:0] addr_len(input logic [7:0] a);
      case (a)
         ADDR_PER:                                               addr_len = 3'd4;
         ADDR_P1WID, ADDR_DEL, ADDR_P2WID, ADDR_NUT_D, ADDR_BL_OFF: addr_len = 3'd2;
         ADDR_NUT_W, ADDR_CP, ADDR_P_BL, ADDR_BL:                 addr_len = 3'd1;
         ADDR_COMMIT:                                            addr_len = 3'd0;
         default:                                                addr_len = LEN_BAD;
      endcase
   endfunction

endpackage

// File: rtl/pulse_param_loader_uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with input synchronizer and mid-bit sampling
module uart_rx_byte
   import pulse_param_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   logic [2:0]    sync;
   rx_state_t     ustate;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;

   // two synchronizer flops plus one history flop so a start needs a real falling edge
   always_ff @(posedge clk or negedge reset)
      if (!reset) sync <= 3'b111;
      else        sync <= {sync[1:0], rxd};

   // bit timing: confirm start at half a bit, then sample each bit and the stop bit at mid-bit
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         ustate    <= RX_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         case (ustate)
            RX_IDLE: begin
               cnt <= '0;
               if (sync[2] && !sync[1]) ustate <= RX_START;
            end
            RX_START:
               if (cnt == HALF) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  ustate  <= sync[1] ? RX_IDLE : RX_DATA;
               end else cnt <= cnt + 1'b1;
            RX_DATA:
               if (cnt == FULL) begin
                  cnt     <= '0;
                  data    <= {sync[1], data[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) ustate <= RX_STOP;
               end else cnt <= cnt + 1'b1;
            default:
               if (cnt == FULL) begin
                  cnt       <= '0;
                  ustate    <= RX_IDLE;
                  valid     <= sync[1];
                  frame_err <= !sync[1];
               end else cnt <= cnt + 1'b1;
         endcase
      end

endmodule

// File: rtl/pulse_param_loader.sv
// pulse_param_loader: UART command parser that stages pulse timing parameters and commits them atomically
module pulse_param_loader
   import pulse_param_loader_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int BAUD        = 115_200,
   parameter int TIMEOUT_CYC = 500_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rxd,
   output logic [31:0] per,
   output logic [15:0] p1wid,
   output logic [15:0] del,
   output logic [15:0] p2wid,
   output logic [7:0]  nut_w,
   output logic [15:0] nut_d,
   output logic [7:0]  cp,
   output logic [7:0]  p_bl,
   output logic [15:0] p_bl_off,
   output logic        bl,
   output logic        rx_done,
   output logic [7:0]  err_cnt,
   output logic        busy
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ferr;
   state_t        state;
   params_t       shadow;
   params_t       live;
   logic [7:0]    addr;
   logic [7:0]    csum;
   logic [31:0]   dbuf;
   logic [1:0]    idx;
   logic [2:0]    len;
   logic [2:0]    rx_len;
   logic [TW-1:0] to_cnt;
   logic [17:0]   span;
   logic          reject;
   logic          csum_ok;
   logic          timed_out;
   logic          abort;
   logic          err_inc;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk       (clk),
      .reset     (reset),
      .rxd       (rxd),
      .data      (rx_data),
      .valid     (rx_valid),
      .frame_err (rx_ferr)
   );

   assign rx_len    = addr_len(rx_data);
   assign span      = 18'(shadow.p1wid) + 18'(shadow.del) + 18'(shadow.p2wid);
   assign reject    = shadow.cp != 8'd0 && 32'(span) >= shadow.per;
   assign csum_ok   = csum == rx_data;
   assign timed_out = state != ST_IDLE && !rx_valid && to_cnt == TW'(TIMEOUT_CYC);
   assign abort     = timed_out || (rx_ferr && state != ST_IDLE);
   assign err_inc   = abort
                    || (rx_valid && state == ST_ADDR && rx_len == LEN_BAD)
                    || (rx_valid && state == ST_CSUM && (!csum_ok || (addr == ADDR_COMMIT && reject)));

   assign per      = live.per;
   assign p1wid    = live.p1wid;
   assign del      = live.del;
   assign p2wid    = live.p2wid;
   assign nut_w    = live.nut_w;
   assign nut_d    = live.nut_d;
   assign cp       = live.cp;
   assign p_bl     = live.p_bl;
   assign p_bl_off = live.p_bl_off;
   assign bl       = live.bl;
   assign busy     = state != ST_IDLE;

   // frame parser, shadow bank, commit to live, error counter and inter-byte timeout
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state   <= ST_IDLE;
         shadow  <= PARAM_DEFAULTS;
         live    <= PARAM_DEFAULTS;
         addr    <= '0;
         csum    <= '0;
         dbuf    <= '0;
         idx     <= '0;
         len     <= '0;
         to_cnt  <= '0;
         rx_done <= 1'b0;
         err_cnt <= '0;
      end else begin
         rx_done <= 1'b0;
         to_cnt  <= (rx_valid || state == ST_IDLE) ? '0 : to_cnt + 1'b1;
         if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         if (abort) state <= ST_IDLE;
         if (rx_valid)
            case (state)
               ST_IDLE: if (rx_data == SYNC_BYTE) state <= ST_ADDR;
               ST_ADDR: begin
                  addr  <= rx_data;
                  csum  <= rx_data;
                  dbuf  <= '0;
                  idx   <= '0;
                  len   <= rx_len;
                  state <= rx_len == LEN_BAD ? ST_IDLE : rx_len == 3'd0 ? ST_CSUM : ST_DATA;
               end
               ST_DATA: begin
                  dbuf[{idx, 3'b000} +: 8] <= rx_data;
                  csum <= csum ^ rx_data;
                  idx  <= idx + 2'd1;
                  if ({1'b0, idx} == len - 3'd1) state <= ST_CSUM;
               end
               default: begin
                  state <= ST_IDLE;
                  if (csum_ok && addr == ADDR_COMMIT && !reject) begin
                     live    <= shadow;
                     rx_done <= 1'b1;
                  end else if (csum_ok)
                     case (addr)
                        ADDR_PER:    shadow.per      <= dbuf;
                        ADDR_P1WID:  shadow.p1wid    <= dbuf[15:0];
                        ADDR_DEL:    shadow.del      <= dbuf[15:0];
                        ADDR_P2WID:  shadow.p2wid    <= dbuf[15:0];
                        ADDR_NUT_W:  shadow.nut_w    <= dbuf[7:0];
                        ADDR_NUT_D:  shadow.nut_d    <= dbuf[15:0];
                        ADDR_CP:     shadow.cp       <= dbuf[7:0];
                        ADDR_P_BL:   shadow.p_bl     <= dbuf[7:0];
                        ADDR_BL_OFF: shadow.p_bl_off <= dbuf[15:0];
                        ADDR_BL:     shadow.bl       <= dbuf[0];
                        default:     ;
                     endcase
               end
            endcase
      end

endmodule

// File: tb/tb_pulse_param_loader.sv
// tb_pulse_param_loader: directed frame tests for the UART parameter loader
module tb_pulse_param_loader;

   localparam int CLK_HZ      = 1_000_000;
   localparam int BAUD        = 100_000;
   localparam int TIMEOUT_CYC = 2000;
   localparam int BIT         = CLK_HZ / BAUD;
   localparam logic [136:0] DEF = {32'd65536, 16'd30, 16'd200, 16'd30, 8'd50, 16'd300,
                                   8'd3, 8'd50, 16'd100, 1'b1};

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rxd = 1'b1;
   logic [31:0] per;
   logic [15:0] p1wid, del, p2wid, nut_d, p_bl_off;
   logic [7:0]  nut_w, cp, p_bl, err_cnt;
   logic        bl, rx_done, busy;
   logic [136:0] live_all;
   int errors = 0;
   int checks = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   pulse_param_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk(clk), .reset(reset), .rxd(rxd), .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
      .nut_w(nut_w), .nut_d(nut_d), .cp(cp), .p_bl(p_bl), .p_bl_off(p_bl_off), .bl(bl),
      .rx_done(rx_done), .err_cnt(err_cnt), .busy(busy)
   );

   assign live_all = {per, p1wid, del, p2wid, nut_w, nut_d, cp, p_bl, p_bl_off, bl};

   always @(negedge clk) if (rx_done === 1'b1) done_cnt++;

   task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
      @(negedge clk) rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (BIT) @(negedge clk);
      end
      rxd = stop;
      repeat (BIT) @(negedge clk);
      rxd = 1'b1;
      repeat (2 * BIT) @(negedge clk);
   endtask

   task automatic commit();
      send_byte(8'hA5); send_byte(8'h0F); send_byte(8'h0F);
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (50) @(negedge clk);
      checks++; if (live_all !== DEF) begin errors++; $display("FAIL reset_live: got %h want %h", live_all, DEF); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL reset_done: got %0d want 0", done_cnt); end
   endtask

   task automatic test_commit_per();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h40); send_byte(8'h0D);
      send_byte(8'h03); send_byte(8'h00); send_byte(8'h4F);
      checks++; if (per !== 32'd65536) begin errors++; $display("FAIL per_precommit: got %0d want 65536", per); end
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL done_precommit: got %0d want 0", done_cnt); end
      commit();
      checks++; if (per !== 32'd200000) begin errors++; $display("FAIL per_commit: got %0d want 200000", per); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL done_commit: got %0d want 1", done_cnt); end
      checks++; if (err_cnt !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL commit_status: err %0d busy %b want 0 0", err_cnt, busy); end
   endtask

   task automatic test_shadow();
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h3C); send_byte(8'h00); send_byte(8'h3E);
      checks++; if (p1wid !== 16'd30) begin errors++; $display("FAIL p1wid_shadow: got %0d want 30", p1wid); end
      commit();
      checks++; if (p1wid !== 16'd60) begin errors++; $display("FAIL p1wid_commit: got %0d want 60", p1wid); end
      checks++; if (done_cnt !== 2) begin errors++; $display("FAIL done_p1wid: got %0d want 2", done_cnt); end
   endtask

   task automatic test_bad_csum();
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'hC8); send_byte(8'h00); send_byte(8'h00);
      checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL csum_err: got %0d want 1", err_cnt); end
      commit();
      checks++; if (del !== 16'd200) begin errors++; $display("FAIL csum_del: got %0d want 200", del); end
      checks++; if (done_cnt !== 3) begin errors++; $display("FAIL csum_done: got %0d want 3", done_cnt); end
   endtask

   task automatic test_reject();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h64); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h65);
      send_byte(8'hA5); send_byte(8'h07); send_byte(8'h03); send_byte(8'h04);
      commit();
      checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL reject_err: got %0d want 2", err_cnt); end
      checks++; if (done_cnt !== 3) begin errors++; $display("FAIL reject_done: got %0d want 3", done_cnt); end
      checks++; if (per !== 32'd200000) begin errors++; $display("FAIL reject_per: got %0d want 200000", per); end
   endtask

   task automatic test_commit_boundary();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h22); send_byte(8'h01);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h22);
      commit();
      checks++; if (err_cnt !== 8'd3 || done_cnt !== 3) begin errors++; $display("FAIL equal_reject: err %0d done %0d want 3 3", err_cnt, done_cnt); end
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h23); send_byte(8'h01);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h23);
      commit();
      checks++; if (per !== 32'd291 || done_cnt !== 4) begin errors++; $display("FAIL above_accept: per %0d done %0d want 291 4", per, done_cnt); end
      send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h64); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h65);
      commit();
      checks++; if (per !== 32'd100 || cp !== 8'd0 || done_cnt !== 5) begin errors++; $display("FAIL cw_accept: per %0d cp %0d done %0d want 100 0 5", per, cp, done_cnt); end
      checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL cw_err: got %0d want 3", err_cnt); end
   endtask

   task automatic test_bad_bytes();
      send_byte(8'h55);
      checks++; if (busy !== 1'b0 || err_cnt !== 8'd3) begin errors++; $display("FAIL idle_junk: busy %b err %0d want 0 3", busy, err_cnt); end
      send_byte(8'hA5); send_byte(8'h0B);
      checks++; if (busy !== 1'b0 || err_cnt !== 8'd4) begin errors++; $display("FAIL bad_addr: busy %b err %0d want 0 4", busy, err_cnt); end
      send_byte(8'hA5);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sync_busy: got %b want 1", busy); end
      send_byte(8'h01, 1'b0);
      checks++; if (busy !== 1'b0 || err_cnt !== 8'd5) begin errors++; $display("FAIL stop_err: busy %b err %0d want 0 5", busy, err_cnt); end
   endtask

   task automatic test_timeout();
      send_byte(8'hA5); send_byte(8'h04);
      repeat (1800) @(negedge clk);
      checks++; if (busy !== 1'b1 || err_cnt !== 8'd5) begin errors++; $display("FAIL pre_timeout: busy %b err %0d want 1 5", busy, err_cnt); end
      repeat (400) @(negedge clk);
      checks++; if (busy !== 1'b0 || err_cnt !== 8'd6) begin errors++; $display("FAIL timeout: busy %b err %0d want 0 6", busy, err_cnt); end
      checks++; if (p2wid !== 16'd30 || done_cnt !== 5) begin errors++; $display("FAIL timeout_live: p2wid %0d done %0d want 30 5", p2wid, done_cnt); end
   endtask

   task automatic test_reset_mid_frame();
      send_byte(8'hA5); send_byte(8'h04); send_byte(8'h3C);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (live_all !== DEF) begin errors++; $display("FAIL mid_reset_live: got %h want %h", live_all, DEF); end
      checks++; if (busy !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL mid_reset_status: busy %b err %0d want 0 0", busy, err_cnt); end
   endtask

   initial begin
      test_reset();
      test_commit_per();
      test_shadow();
      test_bad_csum();
      test_reject();
      test_commit_boundary();
      test_bad_bytes();
      test_timeout();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
